// File: rtl/uart_tx_frame_gen_if.sv
// Parallel-word handshake into the UART transmitter: the producer drives in_valid/data_in,
// the transmitter answers with in_ready.
interface uart_tx_frame_gen_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              in_ready;

  modport master (output in_valid, output data_in, input in_ready);
  modport slave  (input in_valid, input data_in, output in_ready);
endinterface

// File: rtl/uart_tx_frame_gen.sv
// Parametrised UART transmitter: start, DATA_W data bits LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry word FIFO in front of the frame FSM.
module uart_tx_frame_gen #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_frame_gen_if.slave            s_in,
  output logic                          tx1,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY_MODE != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_frame_gen: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame_gen: STOP_BITS must be 1 or 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
    $error("uart_tx_frame_gen: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_baud
    $error("uart_tx_frame_gen: CLKS_PER_BIT must be >= 1");
  end

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic                r_tx;
  logic                r_done;

  logic                w_start;
  logic [DATA_W-1:0]   w_word;
  logic                w_bit_end;

  state_t              w_nxt_state;
  logic [CNT_W-1:0]    w_nxt_cnt;
  logic [BIT_W-1:0]    w_nxt_bit;
  logic [DATA_W-1:0]   w_nxt_shift;
  logic                w_nxt_par;
  logic                w_nxt_tx;
  logic                w_nxt_done;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  assign w_full         = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty        = (r_level == '0);
  // A full FIFO refuses a push even when the FSM pops in the same cycle.
  assign w_push         = s_in.in_valid && !w_full;
  assign w_pop          = (r_state == S_IDLE) && !w_empty;
  assign s_in.in_ready  = !w_full;
  assign w_start        = w_pop;
  assign w_word         = r_mem[r_rd_ptr];
  assign fifo_level     = r_level;

  // NOTE: the storage array is deliberately not reset; emptying is done by the pointers
  // and level, and a resettable memory would cost a mux per bit for no functional gain.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_in.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
`else
  assign w_start        = s_in.in_valid && (r_state == S_IDLE);
  assign w_word         = s_in.data_in;
  assign s_in.in_ready  = (r_state == S_IDLE);
  assign fifo_level     = '0;
`endif

  assign w_bit_end = (r_cnt == CNT_LAST);

  // NOTE: every variable gets a default before the case tree so no path can infer a latch.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_bit   = r_bit;
    w_nxt_shift = r_shift;
    w_nxt_par   = r_par;
    if (r_state == S_IDLE) begin
      w_nxt_cnt = '0;
      w_nxt_bit = '0;
      if (w_start) begin
        w_nxt_state = S_START;
        w_nxt_shift = w_word;
        w_nxt_par   = (PARITY_MODE == 2) ? ~^w_word : ^w_word;
      end
    end else if (!w_bit_end) begin
      w_nxt_cnt = r_cnt + 1'b1;
    end else begin
      w_nxt_cnt = '0;
      case (r_state)
        S_START: begin
          w_nxt_state = S_DATA;
          w_nxt_bit   = '0;
        end
        S_DATA: begin
          w_nxt_shift = r_shift >> 1;
          if (r_bit == DATA_LAST) begin
            w_nxt_bit   = '0;
            w_nxt_state = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            w_nxt_bit = r_bit + 1'b1;
          end
        end
        S_PARITY: begin
          w_nxt_state = S_STOP;
          w_nxt_bit   = '0;
        end
        S_STOP: begin
          if (r_bit == STOP_LAST) w_nxt_state = S_IDLE;
          else                    w_nxt_bit   = r_bit + 1'b1;
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  // Line level and the end-of-frame pulse are decoded from the next state so both are registered.
  always_comb begin
    w_nxt_tx = 1'b1;
    case (w_nxt_state)
      S_START:  w_nxt_tx = 1'b0;
      S_DATA:   w_nxt_tx = w_nxt_shift[0];
      S_PARITY: w_nxt_tx = w_nxt_par;
      default:  w_nxt_tx = 1'b1;
    endcase
    w_nxt_done = (w_nxt_state == S_STOP) && (w_nxt_bit == STOP_LAST) && (w_nxt_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_bit   <= w_nxt_bit;
      r_shift <= w_nxt_shift;
      r_par   <= w_nxt_par;
      r_tx    <= w_nxt_tx;
      r_done  <= w_nxt_done;
    end
  end

  assign tx1        = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: four instances (even, odd, no parity, two stop bits),
// CLKS_PER_BIT=4; the FIFO scenario runs when UART_TX_FIFO_EN is defined.
module tb_uart_tx_frame_gen;

  localparam int CPB = 4;
  localparam int PAR_TAB  [4] = '{1, 2, 0, 1};
  localparam int STOP_TAB [4] = '{1, 1, 1, 2};
`ifdef UART_TX_FIFO_EN
  localparam logic RDY_IN_FRAME = 1'b1;
`else
  localparam logic RDY_IN_FRAME = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] v;
  logic [7:0] d [4];
  wire  [3:0] tx, busy, done, rdy;
  wire  [2:0] lvl [4];
  int         cyc;
  int         n_total;
  int         n_bad;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_frame_gen_if #(.DATA_W(8)) u_if ();
    assign u_if.in_valid = v[g];
    assign u_if.data_in  = d[g];
    assign rdy[g]        = u_if.in_ready;
    uart_tx_frame_gen #(
      .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(PAR_TAB[g]),
      .STOP_BITS(STOP_TAB[g]), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk), .rst(rst), .s_in(u_if.slave), .tx1(tx[g]), .busy(busy[g]),
      .frame_done(done[g]), .fifo_level(lvl[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered one sample after the frame's first clk edge; ends in the idle clk after the frame.
  task automatic watch_frame(input int idx, input int nbits, input logic [11:0] exp, input string tag);
    logic [3:0] smp;
    int k, done_at, done_cnt, busy_cnt, rdy_cnt;
    k = 0; done_at = 0; done_cnt = 0; busy_cnt = 0; rdy_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        k++;
        smp[c] = tx[idx];
        if (busy[idx] === 1'b1) busy_cnt++;
        if (rdy[idx] === RDY_IN_FRAME) rdy_cnt++;
        if (done[idx] === 1'b1) begin
          done_cnt++;
          if (done_at == 0) done_at = k;
        end
        @(posedge clk); #1;
      end
      check($sformatf("%s bit%0d", tag, b), smp, {4{exp[11-b]}});
    end
    check($sformatf("%s frame_done clk", tag), done_at, nbits * CPB);
    check($sformatf("%s frame_done pulses", tag), done_cnt, 1);
    check($sformatf("%s busy clks", tag), busy_cnt, nbits * CPB);
    check($sformatf("%s in_ready in frame", tag), rdy_cnt, nbits * CPB);
    check($sformatf("%s idle after {tx,busy,done,rdy,lvl}", tag),
          {tx[idx], busy[idx], done[idx], rdy[idx], lvl[idx]}, {4'b1001, 3'd0});
  endtask

  task automatic send_frame(input int idx, input logic [7:0] word, input int nbits,
                            input logic [11:0] exp, input string tag);
    @(negedge clk);
    v[idx] = 1'b1;
    d[idx] = word;
    check($sformatf("%s ready before accept", tag), rdy[idx], 1);
    @(posedge clk); #1;
    v[idx] = 1'b0;
    d[idx] = ~word;
`ifdef UART_TX_FIFO_EN
    check($sformatf("%s queued {tx,busy}", tag), {tx[idx], busy[idx]}, 2'b10);
    @(posedge clk); #1;
`endif
    watch_frame(idx, nbits, exp, tag);
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic back_to_back(input int idx, input logic [7:0] w1, input logic [11:0] e1,
                              input logic [7:0] w2, input logic [11:0] e2, input int nbits,
                              input string tag);
    int busy_cnt;
    @(negedge clk);
    v[idx] = 1'b1;
    d[idx] = w1;
    @(posedge clk); #1;
    d[idx] = w2;
    watch_frame(idx, nbits, e1, {tag, " w1"});
    @(posedge clk); #1;
    v[idx] = 1'b0;
    d[idx] = 8'h00;
    watch_frame(idx, nbits, e2, {tag, " w2"});
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (busy[idx] === 1'b1) busy_cnt++;
    end
    check({tag, " no duplicate frame"}, busy_cnt, 0);
  endtask
`endif

`ifdef UART_TX_FIFO_EN
  logic [7:0] fw [6];

  task automatic rx_frames();
    int wait_n, start_prev;
    logic [10:0] bits;
    start_prev = 0;
    for (int f = 0; f < 6; f++) begin
      wait_n = 0;
      while (tx[0] !== 1'b0 && wait_n < 300) begin
        @(posedge clk); #1;
        wait_n++;
      end
      check($sformatf("fifo frame%0d start seen", f), wait_n < 300, 1);
      if (wait_n >= 300) break;
      if (f > 0) check($sformatf("fifo frame%0d spacing", f), cyc - start_prev, 45);
      start_prev = cyc;
      @(posedge clk); #1;
      bits[0] = tx[0];
      for (int j = 1; j < 11; j++) begin
        repeat (CPB) @(posedge clk);
        #1;
        bits[j] = tx[0];
      end
      check($sformatf("fifo frame%0d data", f), bits[8:1], fw[f]);
      check($sformatf("fifo frame%0d parity", f), bits[9], ^fw[f]);
      check($sformatf("fifo frame%0d {stop,start}", f), {bits[10], bits[0]}, 2'b10);
    end
  endtask

  task automatic push_words();
    int wait_n;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v[0] = 1'b1;
      d[0] = fw[i];
      check($sformatf("fifo push%0d ready", i), rdy[0], 1);
      @(posedge clk); #1;
    end
    check("fifo full {lvl,rdy,busy}", {lvl[0], rdy[0], busy[0]}, {3'd4, 2'b01});
    d[0] = fw[5];
    wait_n = 0;
    while (lvl[0] == 3'd4 && wait_n < 300) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("fifo level after pop while full", lvl[0], 3);
    @(posedge clk); #1;
    check("fifo level after held push", lvl[0], 4);
    v[0] = 1'b0;
  endtask
`endif

  typedef struct {
    int         idx;
    logic [7:0] word;
    int         nbits;
    logic [11:0] frame;   // transmitted bits, first bit at [11]
    string      tag;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, 8'hA5, 11, 12'b0101_0010_1010, "even A5"};
    vecs[1] = '{0, 8'h01, 11, 12'b0100_0000_0110, "even 01"};
    vecs[2] = '{1, 8'h00, 11, 12'b0000_0000_0110, "odd 00"};
    vecs[3] = '{1, 8'h07, 11, 12'b0111_0000_0010, "odd 07"};
    vecs[4] = '{2, 8'hFF, 10, 12'b0111_1111_1100, "none FF"};
    vecs[5] = '{3, 8'h3C, 12, 12'b0001_1110_0011, "stop2 3C"};
    vecs[6] = '{2, 8'h5A, 10, 12'b0010_1101_0100, "none 5A"};
`ifdef UART_TX_FIFO_EN
    fw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hEE};
`endif
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    rst     = 1'b1;
    v       = '0;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset {tx,busy,done}", {tx, busy, done}, {4'hF, 4'h0, 4'h0});
    check("reset fifo_level", lvl[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready after release", rdy, 4'hF);

    for (int i = 0; i < 7; i++)
      send_frame(vecs[i].idx, vecs[i].word, vecs[i].nbits, vecs[i].frame, vecs[i].tag);

`ifndef UART_TX_FIFO_EN
    back_to_back(3, 8'h3C, 12'b0001_1110_0011, 8'hC3, 12'b0110_0001_1011, 12, "stop2 held");
    back_to_back(0, 8'h11, 12'b0100_0100_0010, 8'h22, 12'b0010_0010_0010, 11, "backpressure");
`endif

    // Reset during data bit 3 of an all-zero word, then a clean frame.
    @(negedge clk);
    v[0] = 1'b1;
    d[0] = 8'h00;
    @(posedge clk); #1;
    v[0] = 1'b0;
`ifdef UART_TX_FIFO_EN
    @(posedge clk); #1;
`endif
    repeat (17) @(posedge clk);
    #1;
    check("mid-frame {tx,busy}", {tx[0], busy[0]}, 2'b01);
    rst = 1'b1;
    #1;
    check("abort {tx,busy,done,rdy,lvl}", {tx[0], busy[0], done[0], rdy[0], lvl[0]}, {4'b1001, 3'd0});
    @(negedge clk);
    rst = 1'b0;
    send_frame(0, 8'h5A, 11, 12'b0010_1101_0010, "after reset 5A");

`ifdef UART_TX_FIFO_EN
    @(posedge clk); #1;
    fork
      push_words();
      rx_frames();
    join
    @(posedge clk); #1;
    check("fifo drained {lvl,busy}", {lvl[0], busy[0]}, 4'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
